// File: rtl/cgra_pkg.sv
// Shared types and default sizing for the CGRA kernel sequencer.
package cgra_pkg;

  localparam int unsigned ITER_WIDTH_DEF     = 16;
  localparam int unsigned TIMEOUT_WIDTH_DEF  = 20;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ACK,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/cgra_kernel_sequencer_if.sv
// Software start/done handshake plus PE-array launch/busy signals.
// slave = sequencer side, master = software/array side.
interface cgra_kernel_sequencer_if
  import cgra_pkg::*;
#(
  parameter int unsigned ITER_WIDTH = ITER_WIDTH_DEF
);

  logic                  Computation_Start;
  logic [ITER_WIDTH-1:0] Iter_Count;
  logic                  PE_Array_Busy;
  logic                  PE_Array_Start;
  logic [ITER_WIDTH-1:0] Iter_Index;
  logic                  Computation_Done;
  logic                  Timeout_Err;

  modport slave (
    input  Computation_Start, Iter_Count, PE_Array_Busy,
    output PE_Array_Start, Iter_Index, Computation_Done, Timeout_Err
  );

  modport master (
    output Computation_Start, Iter_Count, PE_Array_Busy,
    input  PE_Array_Start, Iter_Index, Computation_Done, Timeout_Err
  );

endinterface

// File: rtl/cgra_seq_watchdog.sv
// Wait-phase watchdog: counts cycles while active, flags the LIMIT-th cycle.
module cgra_seq_watchdog #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (active) begin
      count <= count + 1'b1;
    end
  end

  // count holds the cycles already spent, so this is the LIMIT-th wait cycle.
  assign expired = active && (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/cgra_kernel_sequencer.sv
// Multi-iteration run controller for the 5x5 PE array.
// Optional watchdog enabled by defining CGRA_SEQ_TIMEOUT_EN.
module cgra_kernel_sequencer
  import cgra_pkg::*;
#(
  parameter int unsigned ITER_WIDTH     = ITER_WIDTH_DEF,
  parameter int unsigned TIMEOUT_WIDTH  = TIMEOUT_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic                    Clk,
  input logic                    Rst,
  cgra_kernel_sequencer_if.slave bus
);

  if (TIMEOUT_CYCLES >= (64'd1 << TIMEOUT_WIDTH)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit in TIMEOUT_WIDTH bits");
  end

  seq_state_t            state;
  seq_state_t            next_state;
  logic [ITER_WIDTH-1:0] iter_index;
  logic [ITER_WIDTH-1:0] iter_total;
  logic                  accept;
  logic                  last_iter;
  logic                  timeout_hit;

  assign accept    = (state == IDLE) && bus.Computation_Start && (bus.Iter_Count != '0);
  assign last_iter = (iter_index == iter_total - 1'b1);

`ifdef CGRA_SEQ_TIMEOUT_EN
  logic wd_clear;
  logic wd_active;
  logic wd_expired;
  logic timeout_err;

  assign wd_active = (state == ACK) || (state == RUN);
  assign wd_clear  = ((next_state == ACK) && (state != ACK)) ||
                     ((next_state == RUN) && (state != RUN));
  // Expiry only counts while the phase is still waiting; a same-cycle busy
  // transition wins and the run proceeds normally.
  assign timeout_hit = wd_expired &&
                       (((state == ACK) && !bus.PE_Array_Busy) ||
                        ((state == RUN) &&  bus.PE_Array_Busy));

  cgra_seq_watchdog #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (Clk),
    .rst     (Rst),
    .clear   (wd_clear),
    .active  (wd_active),
    .expired (wd_expired)
  );

  always_ff @(posedge Clk) begin
    if (Rst || accept) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end

  assign bus.Timeout_Err = timeout_err;
`else
  assign timeout_hit     = 1'b0;
  assign bus.Timeout_Err = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state takes a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.Computation_Start) begin
          next_state = (bus.Iter_Count != '0) ? LAUNCH : DONE;
        end
      end
      LAUNCH: next_state = ACK;
      ACK: begin
        if (bus.PE_Array_Busy) begin
          next_state = RUN;
        end else if (timeout_hit) begin
          next_state = DONE;
        end
      end
      RUN: begin
        if (!bus.PE_Array_Busy) begin
          next_state = last_iter ? DONE : LAUNCH;
        end else if (timeout_hit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (!bus.Computation_Start) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Iteration bookkeeping: the count is captured once, so later Iter_Count
  // changes cannot alter a run in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      iter_index <= '0;
      iter_total <= '0;
    end else if (accept) begin
      iter_index <= '0;
      iter_total <= bus.Iter_Count;
    end else if ((state == RUN) && !bus.PE_Array_Busy && !last_iter) begin
      iter_index <= iter_index + 1'b1;
    end
  end

  always_comb begin
    bus.PE_Array_Start   = 1'b0;
    bus.Computation_Done = 1'b0;
    case (state)
      LAUNCH:  bus.PE_Array_Start   = 1'b1;
      DONE:    bus.Computation_Done = 1'b1;
      default: ;
    endcase
  end

  assign bus.Iter_Index = iter_index;

endmodule
